vertical_timing: RTL

VERTICAL_TIMING -- requirements
Module: vertical_timing

---
 rtl/video_timing_pkg.sv | 22 ++
 rtl/vertical_timing.sv | 97 +++++++++
 2 files changed

// File: rtl/video_timing_pkg.sv
// Shared vertical-timing definitions: region encoding, default counter width, region sequencing.
package video_timing_pkg;

    localparam int VT_CNT_W_DEFAULT = 12;

    typedef enum logic [1:0] {
        VSYNC   = 2'd0,
        VBP     = 2'd1,
        VACTIVE = 2'd2,
        VFP     = 2'd3
    } vstate_t;

    function automatic vstate_t next_region(input vstate_t s);
        case (s)
            VSYNC:   next_region = VBP;
            VBP:     next_region = VACTIVE;
            VACTIVE: next_region = VFP;
            default: next_region = VSYNC;
        endcase
    endfunction

endpackage

// File: rtl/vertical_timing.sv
// Vertical frame sequencer stepped by line_end; registered outputs, latency 1, no backpressure (holds while line_end low).
// Optional VERTICAL_TIMING_FRAME_CNT_EN adds a 16-bit wrapping frame counter output frame_cnt.
module vertical_timing
    import video_timing_pkg::*;
#(
    parameter int CNT_W = VT_CNT_W_DEFAULT
) (
    input  logic             clock_50,
    input  logic             reset,
    input  logic             line_end,
    input  logic [CNT_W-1:0] v_sync_length,
    input  logic [CNT_W-1:0] v_back_porch,
    input  logic [CNT_W-1:0] v_active_lines,
    input  logic [CNT_W-1:0] v_front_porch,
    output logic             v_sync,
    output logic             v_active_flag,
    output logic             frame_start,
    output logic [CNT_W-1:0] line_num
`ifdef VERTICAL_TIMING_FRAME_CNT_EN
    ,
    output logic [15:0]      frame_cnt
`endif
);

    vstate_t          state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [CNT_W-1:0] sh_sync, sh_bp, sh_active, sh_fp;
    logic [CNT_W-1:0] region_len, region_last;
    logic             frame_wrap;

    always_comb begin
        region_len = sh_sync;
        case (state)
            VSYNC:   region_len = sh_sync;
            VBP:     region_len = sh_bp;
            VACTIVE: region_len = sh_active;
            default: region_len = sh_fp;
        endcase
        // A zero length still occupies one line.
        region_last = (region_len == '0) ? '0 : region_len - CNT_W'(1);
    end

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        frame_wrap = 1'b0;
        if (line_end) begin
            if (cnt == region_last) begin
                state_nxt  = next_region(state);
                cnt_nxt    = '0;
                frame_wrap = (state == VFP);
            end else begin
                cnt_nxt = cnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clock_50) begin
        if (reset) begin
            state         <= VSYNC;
            cnt           <= '0;
            v_sync        <= 1'b1;
            v_active_flag <= 1'b0;
            frame_start   <= 1'b0;
            line_num      <= '0;
            sh_sync       <= v_sync_length;
            sh_bp         <= v_back_porch;
            sh_active     <= v_active_lines;
            sh_fp         <= v_front_porch;
        end else begin
            state         <= state_nxt;
            cnt           <= cnt_nxt;
            v_sync        <= (state_nxt == VSYNC);
            v_active_flag <= (state_nxt == VACTIVE);
            frame_start   <= frame_wrap;
            line_num      <= (state_nxt == VACTIVE) ? cnt_nxt : '0;
            // New lengths only take hold at a frame boundary.
            if (frame_wrap) begin
                sh_sync   <= v_sync_length;
                sh_bp     <= v_back_porch;
                sh_active <= v_active_lines;
                sh_fp     <= v_front_porch;
            end
        end
    end

`ifdef VERTICAL_TIMING_FRAME_CNT_EN
    always_ff @(posedge clock_50) begin
        if (reset) begin
            frame_cnt <= '0;
        end else if (frame_wrap) begin
            frame_cnt <= frame_cnt + 16'd1;
        end
    end
`endif

endmodule
